// File: rtl/pyrm_scoreboard_bypass.sv
// ============================================================================
// Module  : pyrm_scoreboard_bypass
// Purpose : Per-register pending-write counters with issue/stall decision and
//           writeback-to-operand bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pyrm_scoreboard_bypass #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NWB  = 2,
    parameter int CNTW = 2
) (
    input  logic                 clk,
    input  logic                 reset_pyri,
    input  logic                 iss_valid_pyri,
    output logic                 iss_retry_pyro,
    input  logic [AW-1:0]        iss_rs1_pyri,
    input  logic [AW-1:0]        iss_rs2_pyri,
    input  logic [AW-1:0]        iss_rd_pyri,
    input  logic                 iss_use_rs1_pyri,
    input  logic                 iss_use_rs2_pyri,
    input  logic                 iss_wr_rd_pyri,
    input  logic [XLEN-1:0]      rf_rs1_pyri,
    input  logic [XLEN-1:0]      rf_rs2_pyri,
    input  logic [NWB-1:0]       wb_valid_pyri,
    input  logic [NWB*AW-1:0]    wb_addr_pyri,
    input  logic [NWB*XLEN-1:0]  wb_data_pyri,
    input  logic                 flush_pyri,
    output logic [XLEN-1:0]      src1_pyro,
    output logic [XLEN-1:0]      src2_pyro,
    output logic [NREG-1:0]      busy_pyro,
    output logic                 err_pyro
);

    localparam int CW = $clog2(NWB + 1);
    localparam int DW = ((CNTW > CW) ? CNTW : CW) + 1;

    logic [CNTW-1:0] cnt_q [NREG];
    logic [CNTW-1:0] cnt_d [NREG];
    logic            err_q;
    logic            err_d;

    logic [CW-1:0]   m1, m2;
    logic            rs1_nz, rs2_nz, rd_nz;
    logic            haz1, haz2, sat, fire;
    logic [DW-1:0]   dec_cnt, sum_cnt;
    logic            underflow;

    assign rs1_nz = (iss_rs1_pyri != '0);
    assign rs2_nz = (iss_rs2_pyri != '0);
    assign rd_nz  = (iss_rd_pyri  != '0);

    // Match counts and bypass muxes; ascending scan lets the highest port win.
    always_comb begin
        m1        = '0;
        m2        = '0;
        src1_pyro = rf_rs1_pyri;
        src2_pyro = rf_rs2_pyri;
        for (int k = 0; k < NWB; k++) begin
            if (wb_valid_pyri[k] && rs1_nz && (wb_addr_pyri[k*AW +: AW] == iss_rs1_pyri)) begin
                m1        = m1 + CW'(1);
                src1_pyro = wb_data_pyri[k*XLEN +: XLEN];
            end
            if (wb_valid_pyri[k] && rs2_nz && (wb_addr_pyri[k*AW +: AW] == iss_rs2_pyri)) begin
                m2        = m2 + CW'(1);
                src2_pyro = wb_data_pyri[k*XLEN +: XLEN];
            end
        end
        if (!rs1_nz) src1_pyro = '0;
        if (!rs2_nz) src2_pyro = '0;
    end

    assign haz1 = iss_use_rs1_pyri && rs1_nz && (DW'(cnt_q[iss_rs1_pyri]) > DW'(m1));
    assign haz2 = iss_use_rs2_pyri && rs2_nz && (DW'(cnt_q[iss_rs2_pyri]) > DW'(m2));
    assign sat  = iss_wr_rd_pyri && rd_nz && (cnt_q[iss_rd_pyri] == {CNTW{1'b1}});

    assign iss_retry_pyro = iss_valid_pyri && (haz1 || haz2 || sat || flush_pyri);
    assign fire           = iss_valid_pyri && !iss_retry_pyro;

    // Next-state counters; an underflowing register clamps to zero and flags error.
    always_comb begin
        err_d     = err_q;
        cnt_d[0]  = '0;
        dec_cnt   = '0;
        sum_cnt   = '0;
        underflow = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            dec_cnt = '0;
            for (int k = 0; k < NWB; k++) begin
                if (wb_valid_pyri[k] && (wb_addr_pyri[k*AW +: AW] == AW'(r)))
                    dec_cnt = dec_cnt + DW'(1);
            end
            sum_cnt   = DW'(cnt_q[r]) +
                        DW'(fire && iss_wr_rd_pyri && (iss_rd_pyri == AW'(r)));
            underflow = (dec_cnt > sum_cnt);
            if (flush_pyri) begin
                cnt_d[r] = '0;
            end else if (underflow) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNTW'(sum_cnt - dec_cnt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end

    assign busy_pyro[0] = 1'b0;
    generate
        for (genvar g = 1; g < NREG; g++) begin : g_busy
            assign busy_pyro[g] = |cnt_q[g];
        end
    endgenerate

    assign err_pyro = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pyrm_scoreboard_bypass.sv
// ============================================================================
// Module  : tb_pyrm_scoreboard_bypass
// Purpose : Directed self-checking bench for the scoreboard with bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pyrm_scoreboard_bypass;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NWB  = 2;
    localparam int CNTW = 2;

    logic                clk = 1'b0;
    logic                reset_pyri;
    logic                iss_valid_pyri;
    logic                iss_retry_pyro;
    logic [AW-1:0]       iss_rs1_pyri, iss_rs2_pyri, iss_rd_pyri;
    logic                iss_use_rs1_pyri, iss_use_rs2_pyri, iss_wr_rd_pyri;
    logic [XLEN-1:0]     rf_rs1_pyri, rf_rs2_pyri;
    logic [NWB-1:0]      wb_valid_pyri;
    logic [NWB*AW-1:0]   wb_addr_pyri;
    logic [NWB*XLEN-1:0] wb_data_pyri;
    logic                flush_pyri;
    logic [XLEN-1:0]     src1_pyro, src2_pyro;
    logic [NREG-1:0]     busy_pyro;
    logic                err_pyro;

    int checks = 0;
    int errors = 0;

    pyrm_scoreboard_bypass #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWB(NWB), .CNTW(CNTW)
    ) dut (
        .clk             (clk),
        .reset_pyri      (reset_pyri),
        .iss_valid_pyri  (iss_valid_pyri),
        .iss_retry_pyro  (iss_retry_pyro),
        .iss_rs1_pyri    (iss_rs1_pyri),
        .iss_rs2_pyri    (iss_rs2_pyri),
        .iss_rd_pyri     (iss_rd_pyri),
        .iss_use_rs1_pyri(iss_use_rs1_pyri),
        .iss_use_rs2_pyri(iss_use_rs2_pyri),
        .iss_wr_rd_pyri  (iss_wr_rd_pyri),
        .rf_rs1_pyri     (rf_rs1_pyri),
        .rf_rs2_pyri     (rf_rs2_pyri),
        .wb_valid_pyri   (wb_valid_pyri),
        .wb_addr_pyri    (wb_addr_pyri),
        .wb_data_pyri    (wb_data_pyri),
        .flush_pyri      (flush_pyri),
        .src1_pyro       (src1_pyro),
        .src2_pyro       (src2_pyro),
        .busy_pyro       (busy_pyro),
        .err_pyro        (err_pyro)
    );

    always #5 clk = ~clk;

    task automatic idle();
        iss_valid_pyri   = 1'b0;
        iss_rs1_pyri     = '0;
        iss_rs2_pyri     = '0;
        iss_rd_pyri      = '0;
        iss_use_rs1_pyri = 1'b0;
        iss_use_rs2_pyri = 1'b0;
        iss_wr_rd_pyri   = 1'b0;
        rf_rs1_pyri      = 64'h1111;
        rf_rs2_pyri      = 64'h2222;
        wb_valid_pyri    = '0;
        wb_addr_pyri     = '0;
        wb_data_pyri     = '0;
        flush_pyri       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic u1, input logic u2,
                         input logic wr);
        iss_valid_pyri   = 1'b1;
        iss_rd_pyri      = rd;
        iss_rs1_pyri     = rs1;
        iss_rs2_pyri     = rs2;
        iss_use_rs1_pyri = u1;
        iss_use_rs2_pyri = u2;
        iss_wr_rd_pyri   = wr;
    endtask

    task automatic do_reset();
        idle();
        reset_pyri = 1'b1;
        #12;
        reset_pyri = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_pyri = 1'b0;
        idle();
        #2 reset_pyri = 1'b1;
        #10 reset_pyri = 1'b0;
        tick();
        checks++;
        if (busy_pyro !== '0) begin
            errors++; $display("FAIL reset_busy: got %h expected 0", busy_pyro);
        end
        checks++;
        if (err_pyro !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", err_pyro);
        end
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL reset_retry: got %b expected 0", iss_retry_pyro);
        end
    endtask

    task automatic test_issue_basic();
        issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL issue_retry: got %b expected 0", iss_retry_pyro);
        end
        checks++;
        if (src1_pyro !== 64'h1111 || src2_pyro !== 64'h2222) begin
            errors++; $display("FAIL issue_rf_src: got %h/%h expected 1111/2222", src1_pyro, src2_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro !== 32'h0000_0020) begin
            errors++; $display("FAIL issue_busy5: got %h expected 00000020", busy_pyro);
        end
    endtask

    task automatic test_raw_bypass();
        issue(5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (iss_retry_pyro !== 1'b1) begin
                errors++; $display("FAIL raw_stall%0d: got %b expected 1", i, iss_retry_pyro);
            end
            tick();
        end
        wb_valid_pyri          = 2'b01;
        wb_addr_pyri[0 +: AW]  = 5'd5;
        wb_data_pyri[0 +: XLEN] = 64'hDEAD_BEEF;
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL raw_wb_retry: got %b expected 0", iss_retry_pyro);
        end
        checks++;
        if (src1_pyro !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL raw_bypass_src1: got %h expected deadbeef", src1_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro[5] !== 1'b0) begin
            errors++; $display("FAIL raw_busy5_clear: got %b expected 0", busy_pyro[5]);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            #1;
            checks++;
            if (iss_retry_pyro !== 1'b0) begin
                errors++; $display("FAIL sat_issue%0d: got %b expected 0", i, iss_retry_pyro);
            end
            tick();
        end
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b1) begin
            errors++; $display("FAIL sat_fourth: got %b expected 1", iss_retry_pyro);
        end
        idle();
        wb_valid_pyri           = 2'b11;
        wb_addr_pyri            = {5'd7, 5'd7};
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro[7] !== 1'b1) begin
            errors++; $display("FAIL sat_busy7_after2: got %b expected 1", busy_pyro[7]);
        end
        wb_valid_pyri          = 2'b10;
        wb_addr_pyri           = {5'd7, 5'd0};
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro[7] !== 1'b0 || err_pyro !== 1'b0) begin
            errors++; $display("FAIL sat_drain: got busy=%b err=%b expected 0/0", busy_pyro[7], err_pyro);
        end
    endtask

    task automatic test_back_to_back();
        issue(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        wb_valid_pyri = 2'b01;
        wb_addr_pyri  = {5'd0, 5'd11};
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL b2b_retry: got %b expected 0", iss_retry_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro[11] !== 1'b1) begin
            errors++; $display("FAIL b2b_net_busy11: got %b expected 1", busy_pyro[11]);
        end
        wb_valid_pyri = 2'b01;
        wb_addr_pyri  = {5'd0, 5'd11};
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro !== '0) begin
            errors++; $display("FAIL b2b_drain: got %h expected 0", busy_pyro);
        end
    endtask

    task automatic test_dual_bypass();
        issue(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        wb_valid_pyri = 2'b11;
        wb_addr_pyri  = {5'd9, 5'd9};
        wb_data_pyri  = {64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
        #1;
        checks++;
        if (src1_pyro !== 64'hBBBB_0000_0000_000B) begin
            errors++; $display("FAIL dual_priority: got %h expected bbbb00000000000b", src1_pyro);
        end
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL dual_retry: got %b expected 0", iss_retry_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (err_pyro !== 1'b1 || busy_pyro[9] !== 1'b0) begin
            errors++; $display("FAIL dual_underflow: got err=%b busy9=%b expected 1/0", err_pyro, busy_pyro[9]);
        end
    endtask

    task automatic test_x0();
        do_reset();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL x0_issue_retry: got %b expected 0", iss_retry_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro !== '0) begin
            errors++; $display("FAIL x0_busy: got %h expected 0", busy_pyro);
        end
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        wb_valid_pyri = 2'b01;
        wb_addr_pyri  = '0;
        wb_data_pyri  = {64'h0, 64'h1};
        #1;
        checks++;
        if (src1_pyro !== 64'h0) begin
            errors++; $display("FAIL x0_src1: got %h expected 0", src1_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (err_pyro !== 1'b0) begin
            errors++; $display("FAIL x0_err: got %b expected 0", err_pyro);
        end
    endtask

    task automatic test_flush_and_reset();
        issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(5'd4, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
        flush_pyri = 1'b1;
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b1) begin
            errors++; $display("FAIL flush_retry: got %b expected 1", iss_retry_pyro);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_pyro !== '0) begin
            errors++; $display("FAIL flush_busy: got %h expected 0", busy_pyro);
        end
        // Underflow on an idle register raises err so reset has something to clear.
        wb_valid_pyri = 2'b01;
        wb_addr_pyri  = {5'd0, 5'd10};
        tick();
        idle();
        issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (iss_retry_pyro !== 1'b1 || err_pyro !== 1'b1 || busy_pyro[6] !== 1'b1) begin
            errors++; $display("FAIL stall_setup: got retry=%b err=%b busy6=%b expected 1/1/1",
                               iss_retry_pyro, err_pyro, busy_pyro[6]);
        end
        #1 reset_pyri = 1'b1;
        #1;
        checks++;
        if (busy_pyro !== '0 || err_pyro !== 1'b0) begin
            errors++; $display("FAIL async_reset_state: got busy=%h err=%b expected 0/0", busy_pyro, err_pyro);
        end
        checks++;
        if (iss_retry_pyro !== 1'b0) begin
            errors++; $display("FAIL async_reset_retry: got %b expected 0", iss_retry_pyro);
        end
        #3 reset_pyri = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_issue_basic();
        test_raw_bypass();
        test_saturation();
        test_back_to_back();
        test_dual_bypass();
        test_x0();
        test_flush_and_reset();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
